// File: rtl/sim_clock_reset_seq_if.sv
// Signal bundle between the simulation-top sequencer and the logic it paces.
// Level signalling only: div is sampled once near the end of HOLD, finish_req is a level request, and every output is a registered level or one-cycle pulse.
interface sim_clock_reset_seq_if #(
   parameter int NUM_DOMAINS = 2,
   parameter int DIV_WIDTH   = 8,
   parameter int CNT_WIDTH   = 32
);
   logic [NUM_DOMAINS*DIV_WIDTH-1:0] div;
   logic                             finish_req;
   logic [NUM_DOMAINS-1:0]           clk_en;
   logic [NUM_DOMAINS-1:0]           nRST_derived;
   logic                             started;
   logic [CNT_WIDTH-1:0]             cycle_count;
   logic                             done;
   logic [1:0]                       done_cause;

   modport master (
      input  div, finish_req,
      output clk_en, nRST_derived, started, cycle_count, done, done_cause
   );

   modport slave (
      output div, finish_req,
      input  clk_en, nRST_derived, started, cycle_count, done, done_cause
   );
endinterface

// File: rtl/sim_clock_reset_seq.sv
// Clock-enable and staggered reset sequencer for the simulation top level.
// One free-running clock drives HOLD -> RELEASE -> WAIT_START -> RUN -> DONE.
module sim_clock_reset_seq #(
   parameter int NUM_DOMAINS = 2,
   parameter int DIV_WIDTH   = 8,
   parameter int RST_HOLD    = 10,
   parameter int START_DELAY = 20,
   parameter int CNT_WIDTH   = 32,
   parameter int TIMEOUT     = 0
) (
   input  logic                          CLK,
   input  logic                          nRST,
   sim_clock_reset_seq_if.master         seqBus,
   output logic [2:0]                    dbgState
);

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int WAIT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam logic [CNT_WIDTH-1:0] TMO_M1 = CNT_WIDTH'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      HOLD       = 3'd0,
      RELEASE    = 3'd1,
      WAIT_START = 3'd2,
      RUN        = 3'd3,
      DONE       = 3'd4
   } seqState_t;

   seqState_t              state, stateNext;
   logic [HOLD_W-1:0]      holdCnt, holdCntNext;
   logic [WAIT_W-1:0]      waitCnt, waitCntNext;
   logic [IDX_W-1:0]       relIdx, relIdxNext;
   logic                   pending, pendingNext;
   logic                   divLatch;

   logic [NUM_DOMAINS-1:0] rstQ, rstNext;
   logic [NUM_DOMAINS-1:0] enQ, enNext;
   logic                   startedQ, startedNext;
   logic [CNT_WIDTH-1:0]   countQ, countNext;
   logic                   doneQ, doneNext;
   logic [1:0]             causeQ, causeNext;

   logic [DIV_WIDTH-1:0]   divQ [NUM_DOMAINS];
   logic [DIV_WIDTH-1:0]   divQNext [NUM_DOMAINS];
   logic [DIV_WIDTH-1:0]   cnt [NUM_DOMAINS];
   logic [DIV_WIDTH-1:0]   cntNext [NUM_DOMAINS];

   logic                   fireFinish, fireTimeout;

   assign fireFinish  = seqBus.finish_req | pending;
   assign fireTimeout = (TIMEOUT != 0) && (countQ == TMO_M1);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= HOLD;
         holdCnt  <= '0;
         waitCnt  <= '0;
         relIdx   <= '0;
         pending  <= 1'b0;
         rstQ     <= '0;
         enQ      <= '0;
         startedQ <= 1'b0;
         countQ   <= '0;
         doneQ    <= 1'b0;
         causeQ   <= 2'b00;
         for (int i = 0; i < NUM_DOMAINS; i++) begin
            divQ[i] <= '0;
            cnt[i]  <= '0;
         end
      end else begin
         state    <= stateNext;
         holdCnt  <= holdCntNext;
         waitCnt  <= waitCntNext;
         relIdx   <= relIdxNext;
         pending  <= pendingNext;
         rstQ     <= rstNext;
         enQ      <= enNext;
         startedQ <= startedNext;
         countQ   <= countNext;
         doneQ    <= doneNext;
         causeQ   <= causeNext;
         for (int i = 0; i < NUM_DOMAINS; i++) begin
            divQ[i] <= divQNext[i];
            cnt[i]  <= cntNext[i];
         end
      end
   end

   always_comb begin
      stateNext   = state;
      holdCntNext = holdCnt;
      waitCntNext = waitCnt;
      relIdxNext  = relIdx;
      pendingNext = pending;
      divLatch    = 1'b0;
      rstNext     = rstQ;
      startedNext = startedQ;
      countNext   = countQ;
      doneNext    = doneQ;
      causeNext   = causeQ;

      case (state)
         HOLD: begin
            if (seqBus.finish_req) pendingNext = 1'b1;
            if (holdCnt == HOLD_W'(RST_HOLD - 1)) begin
               divLatch  = 1'b1;
               stateNext = RELEASE;
            end else begin
               holdCntNext = holdCnt + 1'b1;
            end
         end
         RELEASE: begin
            if (seqBus.finish_req) pendingNext = 1'b1;
            rstNext[relIdx] = 1'b1;
            if (relIdx == IDX_W'(NUM_DOMAINS - 1)) begin
               stateNext = WAIT_START;
            end else begin
               relIdxNext = relIdx + 1'b1;
            end
         end
         WAIT_START: begin
            if (seqBus.finish_req) pendingNext = 1'b1;
            if (waitCnt == WAIT_W'(START_DELAY - 1)) begin
               stateNext   = RUN;
               startedNext = 1'b1;
            end else begin
               waitCntNext = waitCnt + 1'b1;
            end
         end
         RUN: begin
            // The count still advances on the edge that ends the run, so a
            // timeout of T leaves cycle_count at exactly T.
            countNext = (countQ == '1) ? countQ : countQ + 1'b1;
            if (fireFinish || fireTimeout) begin
               stateNext   = DONE;
               doneNext    = 1'b1;
               causeNext   = {fireTimeout, fireFinish};
               startedNext = 1'b0;
               rstNext     = '0;
            end
         end
         DONE: begin
            stateNext = DONE;
         end
         default: begin
            stateNext = HOLD;
         end
      endcase
   end

   // Enables are computed from next-cycle values so a domain with div_q=0
   // pulses on the very edge its reset is released.
   always_comb begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         divQNext[i] = divLatch ? seqBus.div[i*DIV_WIDTH +: DIV_WIDTH] : divQ[i];
         if (!rstNext[i] || !rstQ[i]) begin
            cntNext[i] = '0;
         end else if (cnt[i] == divQ[i]) begin
            cntNext[i] = '0;
         end else begin
            cntNext[i] = cnt[i] + 1'b1;
         end
         enNext[i] = rstNext[i] && (cntNext[i] == divQNext[i]);
      end
   end

   assign seqBus.clk_en       = enQ;
   assign seqBus.nRST_derived = rstQ;
   assign seqBus.started      = startedQ;
   assign seqBus.cycle_count  = countQ;
   assign seqBus.done         = doneQ;
   assign seqBus.done_cause   = causeQ;
   assign dbgState            = state;

endmodule

// File: doc/sim_clock_reset_seq.md
# sim_clock_reset_seq

Parametrised clock-enable and reset sequencer for the simulation top level. It replaces hand-written `initial`/delay sequencing with cycle-accurate RTL. From one free-running clock it generates per-domain clock enables and staggered active-low domain resets, a start indication and a run-cycle counter. It terminates the run on a timeout or a software finish request.

## Interface
Parameters:
- NUM_DOMAINS, 2: number of derived domains (1..16).
- DIV_WIDTH, 8: width of each per-domain divider value.
- RST_HOLD, 10: cycles all domain resets stay asserted after nRST release (>=1).
- START_DELAY, 20: cycles from last domain release to `started` (>=1).
- CNT_WIDTH, 32: width of `cycle_count`.
- TIMEOUT, 0: run-cycle limit; 0 disables timeout.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- div  in  NUM_DOMAINS*DIV_WIDTH  per-domain divider; domain i uses bits [i*DIV_WIDTH +: DIV_WIDTH].
- finish_req  in  1  level request to end the run.
- clk_en  out  NUM_DOMAINS  per-domain one-cycle clock-enable pulses.
- nRST_derived  out  NUM_DOMAINS  per-domain active-low resets.
- started  out  1  level; high while in RUN.
- cycle_count  out  CNT_WIDTH  cycles spent in RUN.
- done  out  1  sticky end-of-run flag.
- done_cause  out  2  {timeout, finish}, captured when done rises.

## Operation
- Reset values (nRST low, asynchronous): clk_en=0, nRST_derived=0, started=0, cycle_count=0, done=0, done_cause=0, state=HOLD, all counters 0, pending-finish flag 0.
- States: HOLD -> RELEASE -> WAIT_START -> RUN -> DONE. DONE is exited only by nRST.
- HOLD: counts RST_HOLD cycles. On the last HOLD cycle, `div` is latched into div_q[i]. Later `div` changes are ignored until the next reset.
- RELEASE: nRST_derived[i] rises in index order, one domain per cycle, domain 0 first. The state moves to WAIT_START after domain NUM_DOMAINS-1 is released.
- WAIT_START: counts START_DELAY cycles, then enters RUN. `started` goes high with the state change.
- Per-domain divider:
  - cnt[i] is held at 0 while nRST_derived[i]=0.
  - Once the domain is released, cnt[i] increments each cycle and wraps to 0 when it equals div_q[i].
  - clk_en[i] = released && cnt[i]==div_q[i], so the pulse period is div_q[i]+1 cycles.
  - div_q=0 gives clk_en high every cycle.
- RUN: cycle_count increments each cycle and saturates at all-ones (no wrap).
- Done conditions in RUN:
  - finish_req sampled high, or
  - TIMEOUT!=0 and cycle_count==TIMEOUT-1 (timeout).
- Entering DONE, same edge:
  - done=1; done_cause captures which condition(s) fired (both bits may be set at once).
  - started=0; all nRST_derived=0; all clk_en=0.
  - cycle_count freezes at its final value.
- finish_req high before RUN sets a pending flag. The first RUN cycle then takes DONE with done_cause=2'b01 and cycle_count=1.
- nRST asserted mid-run returns everything to reset values immediately. The HOLD sequence restarts when nRST deasserts.

## Timing
- Edge 1 is the first rising edge with nRST high. HOLD occupies edges 1..RST_HOLD.
- nRST_derived[i] rises at edge RST_HOLD+1+i.
- started rises at edge RST_HOLD+NUM_DOMAINS+START_DELAY.
- First clk_en[i] pulse: div_q[i] cycles after nRST_derived[i] rises (same cycle when div_q=0).
- cycle_count=N in the Nth cycle after started rises. With TIMEOUT=T, done rises at the edge where cycle_count reaches T, i.e. T cycles after started.
- finish_req sampled at edge k in RUN: done=1 and resets low after edge k; latency 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Defaults, div={8'd3,8'd0}: nRST_derived[0] rises edge 11 and [1] at edge 12; started at edge 32. clk_en[0] every cycle from edge 11; clk_en[1] every 4th cycle from edge 15.
- TIMEOUT=100, no finish: done at 100 cycles after started; done_cause=2'b10; cycle_count=100; all nRST_derived=0.
- finish_req pulsed 50 cycles into RUN: done next edge; done_cause=2'b01; cycle_count=50; clk_en all 0 thereafter.
- TIMEOUT=10 and finish_req asserted on the cycle cycle_count=9: done_cause=2'b11.
- finish_req held from reset: done on the first RUN cycle; cycle_count=1; done_cause=2'b01.
- nRST pulsed low during RUN at cycle 40: outputs return to reset values asynchronously. The full sequence repeats, using a new `div` latched in HOLD. CNT_WIDTH=4 with TIMEOUT=0 saturates at 15.
